// File: rtl/uart_alu_pkg.sv
// uart_alu_pkg: opcode constants and state encoding shared by the UART/ALU
// frame assembler and its ALU.
package uart_alu_pkg;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_NOR = 6'h27;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_SRL = 6'h02;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    SEND    = 3'd3,
    WAIT_TX = 3'd4
  } state_t;

endpackage

// File: rtl/uart_alu_interface_alu.sv
// alu: combinational ALU evaluated on the opcode byte. Arithmetic wraps
// modulo 2^NB_DATA; unknown opcodes yield zero.
module alu
  import uart_alu_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic [NB_DATA-1:0] i_a,
  input  logic [NB_DATA-1:0] i_b,
  input  logic [NB_OP-1:0]   i_op,
  output logic [NB_DATA-1:0] o_result
);

  // Shift amounts at or beyond the operand width saturate explicitly.
  localparam logic [NB_DATA-1:0] LP_WIDTH = NB_DATA[NB_DATA-1:0];

  // Opcode decode and result selection.
  always_comb begin
    o_result = '0;
    case (i_op)
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_NOR:  o_result = ~(i_a | i_b);
      OP_SRA:  o_result = (i_b >= LP_WIDTH) ? {NB_DATA{i_a[NB_DATA-1]}}
                                            : NB_DATA'($signed(i_a) >>> i_b);
      OP_SRL:  o_result = (i_b >= LP_WIDTH) ? '0 : (i_a >> i_b);
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/uart_alu_interface.sv
// uart_alu_interface: collects operand A, operand B and opcode bytes from the
// UART receiver, evaluates the ALU and hands the result byte to the UART
// transmitter with a start/done handshake.
// Optional feature: define UART_IF_TIMEOUT_EN to discard partial frames after
// TIMEOUT_CYCLES idle cycles in WAIT_B / WAIT_OP.
module uart_alu_interface
  import uart_alu_pkg::*;
#(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_rx_done_tick,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_tx_done_tick,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_overrun,
  output logic               o_timeout
);

  state_t             r_state;
  state_t             w_next;
  logic [NB_DATA-1:0] r_a;
  logic [NB_DATA-1:0] r_b;
  logic [NB_DATA-1:0] r_result;
  logic               r_overrun;
  logic [NB_DATA-1:0] w_alu_result;
  logic               w_timeout_hit;
  logic               w_busy;

  alu #(
    .NB_DATA (NB_DATA),
    .NB_OP   (NB_OP)
  ) u_alu (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_op     (i_rx_data[NB_OP-1:0]),
    .o_result (w_alu_result)
  );

  // A result is pending or being transmitted; incoming bytes are dropped.
  assign w_busy = (r_state == SEND) || (r_state == WAIT_TX);

`ifdef UART_IF_TIMEOUT_EN
  localparam int                  LP_CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [LP_CNT_W-1:0] LP_CNT_MAX = LP_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [LP_CNT_W-1:0] r_cnt;
  logic                r_timeout;
  logic                w_partial;

  assign w_partial     = (r_state == WAIT_B) || (r_state == WAIT_OP);
  // An arriving byte in the expiry cycle wins over the timeout.
  assign w_timeout_hit = w_partial && (r_cnt == LP_CNT_MAX) && !i_rx_done_tick;

  // Inter-byte idle counter, cleared on every accepted byte or outside a partial frame.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_timeout_hit;
      if (w_partial && !i_rx_done_tick && !w_timeout_hit) r_cnt <= r_cnt + 1'b1;
      else                                                r_cnt <= '0;
    end
  end

  assign o_timeout = r_timeout;
`else
  assign w_timeout_hit = 1'b0;
  assign o_timeout     = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= WAIT_A;
    else         r_state <= w_next;
  end

  // Next-state logic for the byte collection and transmit handshake.
  always_comb begin
    w_next = r_state;
    case (r_state)
      WAIT_A:  if (i_rx_done_tick) w_next = WAIT_B;
      WAIT_B:  if (i_rx_done_tick) w_next = WAIT_OP;
               else if (w_timeout_hit) w_next = WAIT_A;
      WAIT_OP: if (i_rx_done_tick) w_next = SEND;
               else if (w_timeout_hit) w_next = WAIT_A;
      SEND:    w_next = WAIT_TX;
      WAIT_TX: if (i_tx_done_tick) w_next = WAIT_A;
      default: w_next = WAIT_A;
    endcase
  end

  // Operand/result capture and sticky overrun flag.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_a       <= '0;
      r_b       <= '0;
      r_result  <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (i_rx_done_tick && (r_state == WAIT_A))  r_a      <= i_rx_data;
      if (i_rx_done_tick && (r_state == WAIT_B))  r_b      <= i_rx_data;
      if (i_rx_done_tick && (r_state == WAIT_OP)) r_result <= w_alu_result;
      if (i_rx_done_tick && w_busy)               r_overrun <= 1'b1;
    end
  end

  assign o_tx_start = (r_state == SEND);
  assign o_tx_data  = r_result;
  assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_uart_alu_interface.sv
// tb_uart_alu_interface: directed and randomized frames against a behavioural
// ALU model; covers handshake timing, overrun, async reset and (optionally)
// the inter-byte timeout.
module tb_uart_alu_interface;

  logic       i_clock = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_rx_done_tick = 1'b0;
  logic [7:0] i_rx_data = 8'h00;
  logic       i_tx_done_tick = 1'b0;
  logic       o_tx_start;
  logic [7:0] o_tx_data;
  logic       o_overrun;
  logic       o_timeout;

  int checks = 0;
  int errors = 0;

  uart_alu_interface #(
    .NB_DATA        (8),
    .NB_OP          (6),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_rx_done_tick (i_rx_done_tick),
    .i_rx_data      (i_rx_data),
    .i_tx_done_tick (i_tx_done_tick),
    .o_tx_start     (o_tx_start),
    .o_tx_data      (o_tx_data),
    .o_overrun      (o_overrun),
    .o_timeout      (o_timeout)
  );

  always #5 i_clock = ~i_clock;

  // Behavioural ALU from the opcode table, using plain integer arithmetic.
  function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] op);
    int o, ia, ib, sa, r;
    o  = int'(op) % 64;
    ia = int'(a);
    ib = int'(b);
    sa = (ia >= 128) ? ia - 256 : ia;
    case (o)
      32:      r = ia + ib;
      34:      r = ia - ib + 256;
      36:      r = ia & ib;
      37:      r = ia | ib;
      38:      r = ia ^ ib;
      39:      r = 255 - (ia | ib);
      3:       r = (ib >= 8) ? ((sa < 0) ? 255 : 0) : (sa >>> ib);
      2:       r = (ib >= 8) ? 0 : (ia / (1 << ib));
      default: r = 0;
    endcase
    return 8'(r & 255);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic rx_byte(input logic [7:0] d);
    i_rx_data      = d;
    i_rx_done_tick = 1'b1;
    tick();
    i_rx_done_tick = 1'b0;
  endtask

  // Sends a full command and checks the start pulse; leaves the DUT in WAIT_TX.
  task automatic frame_start(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] op, input string tag);
    logic [7:0] exp;
    exp = ref_alu(a, b, op);
    rx_byte(a);
    rx_byte(b);
    chk({tag, "_nostart_early"}, 32'(o_tx_start), 32'd0);
    rx_byte(op);
    chk({tag, "_start"}, 32'(o_tx_start), 32'd1);
    chk({tag, "_data"}, 32'(o_tx_data), 32'(exp));
    tick();
    chk({tag, "_start_once"}, 32'(o_tx_start), 32'd0);
  endtask

  task automatic tx_done();
    i_tx_done_tick = 1'b1;
    tick();
    i_tx_done_tick = 1'b0;
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] op, input string tag);
    frame_start(a, b, op, tag);
    tx_done();
  endtask

  // Asserts reset mid-cycle and checks outputs clear before any clock edge.
  task automatic async_reset(input string tag);
    #2;
    i_reset = 1'b1;
    #1;
    chk({tag, "_start"},   32'(o_tx_start), 32'd0);
    chk({tag, "_data"},    32'(o_tx_data),  32'd0);
    chk({tag, "_overrun"}, 32'(o_overrun),  32'd0);
    chk({tag, "_timeout"}, 32'(o_timeout),  32'd0);
    tick();
    i_reset = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] ops [11];
    int extra_pulse, data_bad;

    ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02, 8'h3F, 8'hE0, 8'h00};

    // Reset state
    tick();
    tick();
    chk("rst_start",   32'(o_tx_start), 32'd0);
    chk("rst_data",    32'(o_tx_data),  32'd0);
    chk("rst_overrun", 32'(o_overrun),  32'd0);
    chk("rst_timeout", 32'(o_timeout),  32'd0);
    i_reset = 1'b0;
    tick();

    // tx_done outside WAIT_TX must be ignored
    tx_done();

    // Basic ADD, then hold off tx_done for 100 cycles
    frame_start(8'h05, 8'h03, 8'h20, "add");
    extra_pulse = 0;
    data_bad    = 0;
    for (int i = 0; i < 100; i++) begin
      if (o_tx_start) extra_pulse++;
      if (o_tx_data !== 8'h08) data_bad++;
      tick();
    end
    chk("hold_pulses", 32'(extra_pulse), 32'd0);
    chk("hold_data",   32'(data_bad),    32'd0);
    tx_done();

    // Directed opcode sweep
    frame(8'h03, 8'h05, 8'h22, "sub");
    frame(8'h80, 8'h02, 8'h03, "sra");
    frame(8'h80, 8'h02, 8'h02, "srl");
    frame(8'h0F, 8'hF0, 8'h27, "nor");
    frame(8'h3C, 8'h0F, 8'h24, "and");
    frame(8'h3C, 8'h0F, 8'h25, "or");
    frame(8'h3C, 8'h0F, 8'h26, "xor");
    frame(8'hAA, 8'h11, 8'h3F, "badop");
    frame(8'h7F, 8'h02, 8'hE0, "op_upper");
    frame(8'hFF, 8'h01, 8'h20, "add_wrap");
    frame(8'h90, 8'h09, 8'h03, "sra_big");
    frame(8'h70, 8'h20, 8'h03, "sra_big_pos");
    frame(8'hFF, 8'h08, 8'h02, "srl_big");

    // Randomized frames
    for (int i = 0; i < 24; i++) begin
      logic [7:0] a, b, op;
      op = ops[$urandom_range(0, 10)];
      if (i % 5 == 4) op = 8'($urandom);
      a  = 8'($urandom);
      b  = (op[5:0] == 6'h02 || op[5:0] == 6'h03) ? 8'($urandom_range(0, 12)) : 8'($urandom);
      tx_done();
      frame(a, b, op, "rand");
    end

    // Overrun: byte during WAIT_TX is dropped and flag sticks
    frame_start(8'h10, 8'h20, 8'h20, "ovr_a");
    chk("ovr_before", 32'(o_overrun), 32'd0);
    rx_byte(8'h55);
    chk("ovr_set", 32'(o_overrun), 32'd1);
    tx_done();
    frame(8'h01, 8'h01, 8'h20, "ovr_next");
    chk("ovr_sticky", 32'(o_overrun), 32'd1);

    // Reset in WAIT_TX (data nonzero, overrun set)
    frame_start(8'h21, 8'h12, 8'h20, "rst_tx_pre");
    async_reset("rst_waittx");
    frame(8'h09, 8'h04, 8'h22, "rst_tx_post");

    // Simultaneous tx_done and rx byte in WAIT_TX
    frame_start(8'h40, 8'h02, 8'h02, "sim");
    i_tx_done_tick = 1'b1;
    i_rx_data      = 8'h77;
    i_rx_done_tick = 1'b1;
    tick();
    i_tx_done_tick = 1'b0;
    i_rx_done_tick = 1'b0;
    chk("sim_ovr", 32'(o_overrun), 32'd1);
    frame(8'h01, 8'h01, 8'h20, "sim_next");

    // Reset in WAIT_OP
    rx_byte(8'h33);
    rx_byte(8'h44);
    async_reset("rst_waitop");
    frame(8'h06, 8'h07, 8'h20, "rst_op_post");

`ifdef UART_IF_TIMEOUT_EN
    // Idle 16 cycles after A: timeout, then a fresh frame
    rx_byte(8'hAB);
    for (int i = 0; i < 15; i++) tick();
    chk("to_not_yet", 32'(o_timeout), 32'd0);
    tick();
    chk("to_pulse", 32'(o_timeout), 32'd1);
    tick();
    chk("to_one_cycle", 32'(o_timeout), 32'd0);
    frame(8'h01, 8'h02, 8'h20, "to_next");

    // Byte arriving on the expiry cycle is accepted
    rx_byte(8'h05);
    for (int i = 0; i < 15; i++) tick();
    rx_byte(8'h04);
    chk("to_expiry_none", 32'(o_timeout), 32'd0);
    rx_byte(8'h22);
    chk("to_expiry_start", 32'(o_tx_start), 32'd1);
    chk("to_expiry_data",  32'(o_tx_data),  32'd1);
    tx_done();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_alu_interface.md
# uart_alu_interface

Frame assembler between the UART receiver and UART transmitter in the TP2 datapath. It collects three received bytes in order (operand A, operand B, opcode), evaluates the ALU, and hands the 8-bit result to the transmitter with a start/done handshake. The result is returned to the host as one byte per three-byte command.

## Interface
Parameters:
- NB_DATA, 8: operand and result width; equals UART data width.
- NB_OP, 6: opcode width; taken from `i_rx_data[NB_OP-1:0]` of the third byte.
- TIMEOUT_CYCLES, 2_000_000: inter-byte timeout in `i_clock` cycles; used only with `UART_IF_TIMEOUT_EN`.

Ports:
- i_clock  in  1  system clock; the block has one clock domain.
- i_reset  in  1  asynchronous, active-high reset.
- i_rx_done_tick  in  1  one-cycle pulse from the receiver; `i_rx_data` is valid in that cycle.
- i_rx_data  in  NB_DATA  received byte.
- i_tx_done_tick  in  1  one-cycle pulse from the transmitter when its frame is finished.
- o_tx_start  out  1  one-cycle pulse that starts a transmission.
- o_tx_data  out  NB_DATA  byte to transmit; held stable from `o_tx_start` until `i_tx_done_tick`.
- o_overrun  out  1  sticky flag: a byte arrived while a result was pending or transmitting.
- o_timeout  out  1  one-cycle pulse when a partial frame is discarded.

## Operation
- States: WAIT_A, WAIT_B, WAIT_OP, SEND, WAIT_TX. Reset state is WAIT_A.
- Transitions:
  - WAIT_A: `i_rx_done_tick` loads reg_a; go to WAIT_B.
  - WAIT_B: `i_rx_done_tick` loads reg_b; go to WAIT_OP.
  - WAIT_OP: `i_rx_done_tick` loads the result register with alu(reg_a, reg_b, `i_rx_data[NB_OP-1:0]`); go to SEND.
  - SEND: lasts exactly one cycle; go to WAIT_TX.
  - WAIT_TX: `i_tx_done_tick` returns to WAIT_A.
- `o_tx_start` = (state == SEND). `o_tx_data` = the result register.
- ALU opcodes:

  | Opcode | Operation | Notes |
  |---|---|---|
  | 0x20 | ADD | |
  | 0x22 | SUB | A−B |
  | 0x24 | AND | |
  | 0x25 | OR | |
  | 0x26 | XOR | |
  | 0x27 | NOR | |
  | 0x03 | SRA | A>>>B, signed |
  | 0x02 | SRL | A>>B |

- Arithmetic is modulo 2^NB_DATA; no carry or overflow output.
- Shift amounts ≥ NB_DATA give:
  - SRL: 0.
  - SRA: all sign bits.
- Any other opcode produces result 0x00. It is still transmitted.
- Opcode bits above NB_OP are ignored.
- Overrun:
  - A byte received in SEND or WAIT_TX is dropped and sets `o_overrun`.
  - `o_overrun` clears only on reset.
- Simultaneous `i_tx_done_tick` and `i_rx_done_tick` in WAIT_TX: the state returns to WAIT_A, the byte is dropped, and `o_overrun` is set.
- `i_tx_done_tick` outside WAIT_TX is ignored.
- Reset mid-frame: registers and state clear immediately, and a transmission in progress is abandoned. Reset values:
  - `o_tx_start` = 0
  - `o_tx_data` = 0x00
  - `o_overrun` = 0
  - `o_timeout` = 0
  - reg_a = reg_b = 0

## Timing
- A byte is accepted on the rising edge that ends its `i_rx_done_tick` cycle.
- Latency: third byte pulse in cycle N → `o_tx_start` high in cycle N+1 only, with `o_tx_data` already valid in N+1.
- No combinational path from any input to `o_tx_start` or `o_tx_data`. All outputs are registered or decoded from state.
- Back-to-back: the cycle after `i_tx_done_tick`, the block is in WAIT_A and accepts a byte.

## Configuration
- Macro `UART_IF_TIMEOUT_EN` defined:
  - A counter runs in WAIT_B and WAIT_OP and clears on every accepted byte.
  - When it reaches TIMEOUT_CYCLES−1 with no byte, the state returns to WAIT_A and `o_timeout` pulses for one cycle.
  - A byte arriving in the expiry cycle wins: it is accepted and there is no timeout.
  - Counter width is $clog2(TIMEOUT_CYCLES).
- Macro not defined:
  - No counter; partial frames wait indefinitely.
  - `o_timeout` is tied to 0; the port remains.

## Structure
- Shared package `uart_alu_pkg` holds:
  - the opcode localparams (OP_ADD … OP_SRL);
  - the state encoding, 3 bits.
- Sub-module `alu`: combinational, parameters NB_DATA and NB_OP, inputs a, b, op, output result. It is instantiated once, fed by reg_a, reg_b and `i_rx_data`.

## Test plan
- Bytes 0x05, 0x03, 0x20 → one `o_tx_start` pulse the cycle after the third byte, `o_tx_data` = 0x08. Hold `i_tx_done_tick` off for 100 cycles → `o_tx_data` stays 0x08 and there is no second pulse.
- Sweep all opcodes:
  - SUB 0x03, 0x05 → 0xFE
  - SRA 0x80, 0x02 → 0xE0
  - SRL 0x80, 0x02 → 0x20
  - NOR 0x0F, 0xF0 → 0x00
  - op 0x3F → 0x00
  - op 0xE0 (upper bits ignored) → ADD
- Byte during WAIT_TX, including on the same cycle as `i_tx_done_tick` → `o_overrun` = 1 and the byte is dropped. The next frame 0x01, 0x01, 0x20 → 0x02.
- With `UART_IF_TIMEOUT_EN` and TIMEOUT_CYCLES = 16:
  - Send A, then idle for 16 cycles → `o_timeout` pulses and the next three bytes form a new frame.
  - A byte on the expiry cycle → no timeout.
- Assert `i_reset` in WAIT_OP, then in WAIT_TX → all outputs return to their reset values asynchronously, and the next frame completes correctly.
